spi_frame_receiver: RTL and testbench

//   Front end of the SPI register path, upstream of the PWM register bank.

---
 rtl/spi_frame_pkg.sv | 20 ++
 rtl/spi_frame_receiver_sync.sv | 31 +++
 rtl/spi_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants and FSM encoding for the SPI frame receiver.
// Frame layout: bit15 R/W, bits14:8 address, bits7:0 data.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAME_BITS / 2);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/spi_frame_receiver_sync.sv
// Pad synchroniser followed by an edge register producing
// a registered level plus single-cycle rise/fall pulses.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the pad through the synchroniser, then register level and edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 16-bit frame receiver producing register write strobes.
// Define SPI_FRAME_READBACK_EN to enable read-frame data return on cipo.
module spi_frame_receiver
    import spi_frame_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'd4,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              cipo
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, unused_copi_rise, unused_copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pad(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .pad(copi),
        .level(copi_lvl), .rise(unused_copi_rise), .fall(unused_copi_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .pad(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic                  frame_start, frame_end, shift_en;
    logic                  unused_sclk_lvl;

    assign unused_sclk_lvl = sclk_lvl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle control; ncs edges take priority over sclk.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        shift_en    = 1'b0;
        unique case (state_q)
            WAIT_IDLE: if (ncs_lvl) state_d = IDLE;
            IDLE: begin
                if (ncs_fall) begin
                    state_d     = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end else begin
                    shift_en = sclk_rise;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // Deserialiser, bit counter and frame completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (frame_start) begin
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (shift_en) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], copi_lvl};
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
            end
            if (frame_end) begin
                if (cnt_q != CNT_FULL) begin
                    frame_err <= 1'b1;
                end else if (shreg_q[15] && shreg_q[14:8] <= MAX_ADDR) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= shreg_q[14:8];
                    wr_data  <= shreg_q[7:0];
                end
            end
        end
    end

`ifdef SPI_FRAME_READBACK_EN
    logic              rd_req_q, rd_load_q, rd_active_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] out_sr_q;

    // Read path: present address after bit 8, load data, shift out on sclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            rd_active_q <= 1'b0;
            rd_addr_q   <= '0;
            out_sr_q    <= '0;
        end else if (state_q != SHIFT || frame_end) begin
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            rd_active_q <= 1'b0;
        end else begin
            rd_req_q  <= shift_en && (cnt_q == CNT_HALF - 1'b1);
            rd_load_q <= 1'b0;
            if (rd_req_q && !shreg_q[7]) begin
                rd_addr_q <= shreg_q[6:0];
                rd_load_q <= 1'b1;
            end
            if (rd_load_q) begin
                out_sr_q    <= (rd_addr_q > MAX_ADDR) ? '0 : rd_data;
                rd_active_q <= 1'b1;
            end else if (rd_active_q && sclk_fall && cnt_q > CNT_HALF) begin
                out_sr_q <= {out_sr_q[DATA_W-2:0], 1'b0};
            end
            if (cnt_q >= CNT_FULL) rd_active_q <= 1'b0;
        end
    end

    assign rd_addr = rd_addr_q;
    assign cipo    = rd_active_q & out_sr_q[DATA_W-1];
`else
    logic unused_rd_data;

    assign unused_rd_data = ^{rd_data, sclk_fall};
    assign rd_addr        = '0;
    assign cipo           = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed testbench for spi_frame_receiver.
// Bit-bangs SPI pads slowly relative to clk and checks strobes/errors.
module tb_spi_frame_receiver;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       wr_valid, frame_err, cipo;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    int vec = 0;
    int errs = 0;
    int wr_seen = 0;
    int err_seen = 0;
    int cipo_hi = 0;
    logic [6:0] a_log[$];
    logic [7:0] d_log[$];
    logic       cipo_cap[0:31];

    spi_frame_receiver #(.MAX_ADDR(7'd4), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .rd_addr(rd_addr), .rd_data(rd_data),
        .cipo(cipo)
    );

    always #5 clk = ~clk;

    // Register bank model: address 2 holds 0xA5, everything else 0.
    assign rd_data = (rd_addr == 7'd2) ? 8'hA5 : 8'h00;

    // Monitor strobes, errors and cipo activity.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_seen++;
            a_log.push_back(wr_addr);
            d_log.push_back(wr_data);
        end
        if (frame_err) err_seen++;
        if (cipo) cipo_hi++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        wr_seen = 0;
        err_seen = 0;
        cipo_hi = 0;
        a_log.delete();
        d_log.delete();
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, input int first, input int last);
        for (int i = first; i < last; i++) begin
            copi = v[n-1-i];
            wait_clk(6);
            cipo_cap[i] = cipo;
            sclk = 1'b1;
            wait_clk(6);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(4);
        ncs = 1'b1;
    endtask

    task automatic do_frame(input logic [31:0] v, input int n);
        cs_low();
        spi_bits(v, n, 0, n);
        cs_high();
        wait_clk(12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        vec++; if (wr_valid !== 1'b0) begin errs++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
        vec++; if (wr_addr !== 7'h00) begin errs++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        vec++; if (wr_data !== 8'h00) begin errs++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        vec++; if (rd_addr !== 7'h00) begin errs++; $display("FAIL reset_rd_addr got %h want 00", rd_addr); end
        vec++; if (cipo !== 1'b0) begin errs++; $display("FAIL reset_cipo got %b want 0", cipo); end
        rst_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write();
        int lat;
        lat = 0;
        clear_mon();
        cs_low();
        spi_bits(32'h8355, 16, 0, 16);
        wait_clk(4);
        ncs = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (wr_valid && lat == 0) lat = i;
        end
        wait_clk(6);
        vec++; if (lat !== SS + 2) begin errs++; $display("FAIL write_latency got %0d want %0d", lat, SS + 2); end
        vec++; if (wr_seen !== 1) begin errs++; $display("FAIL write_strobes got %0d want 1", wr_seen); end
        vec++; if (err_seen !== 0) begin errs++; $display("FAIL write_errs got %0d want 0", err_seen); end
        vec++; if (wr_addr !== 7'h03) begin errs++; $display("FAIL write_addr got %h want 03", wr_addr); end
        vec++; if (wr_data !== 8'h55) begin errs++; $display("FAIL write_data got %h want 55", wr_data); end
    endtask

    task automatic test_addr_range();
        clear_mon();
        do_frame(32'h90AA, 16);
        vec++; if (wr_seen !== 0) begin errs++; $display("FAIL oob_strobes got %0d want 0", wr_seen); end
        vec++; if (err_seen !== 0) begin errs++; $display("FAIL oob_errs got %0d want 0", err_seen); end
        vec++; if (wr_addr !== 7'h03) begin errs++; $display("FAIL oob_addr_held got %h want 03", wr_addr); end
        vec++; if (wr_data !== 8'h55) begin errs++; $display("FAIL oob_data_held got %h want 55", wr_data); end
        clear_mon();
        do_frame(32'h843C, 16);
        vec++; if (wr_seen !== 1) begin errs++; $display("FAIL max_addr_strobes got %0d want 1", wr_seen); end
        vec++; if (wr_addr !== 7'h04) begin errs++; $display("FAIL max_addr_addr got %h want 04", wr_addr); end
        vec++; if (wr_data !== 8'h3C) begin errs++; $display("FAIL max_addr_data got %h want 3c", wr_data); end
    endtask

    task automatic test_bad_len();
        int lens[3] = '{15, 17, 0};
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            do_frame(32'h1_8355, lens[k]);
            vec++; if (err_seen !== 1) begin errs++; $display("FAIL badlen_%0d_errs got %0d want 1", lens[k], err_seen); end
            vec++; if (wr_seen !== 0) begin errs++; $display("FAIL badlen_%0d_strobes got %0d want 0", lens[k], wr_seen); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        cs_low();
        spi_bits(32'h8166, 16, 0, 9);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        spi_bits(32'h8166, 16, 9, 16);
        cs_high();
        wait_clk(12);
        vec++; if (wr_seen !== 0) begin errs++; $display("FAIL midrst_strobes got %0d want 0", wr_seen); end
        vec++; if (err_seen !== 0) begin errs++; $display("FAIL midrst_errs got %0d want 0", err_seen); end
        vec++; if (wr_addr !== 7'h00) begin errs++; $display("FAIL midrst_addr got %h want 00", wr_addr); end
        clear_mon();
        do_frame(32'h8142, 16);
        vec++; if (wr_seen !== 1) begin errs++; $display("FAIL postrst_strobes got %0d want 1", wr_seen); end
        vec++; if (wr_addr !== 7'h01) begin errs++; $display("FAIL postrst_addr got %h want 01", wr_addr); end
        vec++; if (wr_data !== 8'h42) begin errs++; $display("FAIL postrst_data got %h want 42", wr_data); end
    endtask

    task automatic test_readback();
        logic [7:0] exp_rd;
        exp_rd = 8'hA5;
        clear_mon();
        do_frame(32'h0200, 16);
        vec++; if (wr_seen !== 0) begin errs++; $display("FAIL read_strobes got %0d want 0", wr_seen); end
        vec++; if (err_seen !== 0) begin errs++; $display("FAIL read_errs got %0d want 0", err_seen); end
`ifdef SPI_FRAME_READBACK_EN
        vec++; if (rd_addr !== 7'h02) begin errs++; $display("FAIL read_rd_addr got %h want 02", rd_addr); end
        for (int k = 0; k < 8; k++) begin
            vec++;
            if (cipo_cap[8+k] !== exp_rd[7-k]) begin
                errs++;
                $display("FAIL read_cipo_bit%0d got %b want %b", 8 + k, cipo_cap[8+k], exp_rd[7-k]);
            end
        end
`else
        vec++; if (cipo_hi !== 0) begin errs++; $display("FAIL cipo_idle got %0d high cycles want 0", cipo_hi); end
        vec++; if (rd_addr !== 7'h00) begin errs++; $display("FAIL rd_addr_idle got %h want 00", rd_addr); end
        vec++; if (exp_rd[7] !== 1'b1) begin errs++; $display("FAIL read_model got %b want 1", exp_rd[7]); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [6:0] a0, a1;
        logic [7:0] d0, d1;
        clear_mon();
        cs_low();
        spi_bits(32'h8011, 16, 0, 16);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(2);
        ncs = 1'b0;
        wait_clk(6);
        spi_bits(32'h8422, 16, 0, 16);
        cs_high();
        wait_clk(12);
        a0 = (a_log.size() > 0) ? a_log[0] : 7'h7F;
        d0 = (d_log.size() > 0) ? d_log[0] : 8'hFF;
        a1 = (a_log.size() > 1) ? a_log[1] : 7'h7F;
        d1 = (d_log.size() > 1) ? d_log[1] : 8'hFF;
        vec++; if (wr_seen !== 2) begin errs++; $display("FAIL b2b_strobes got %0d want 2", wr_seen); end
        vec++; if (err_seen !== 0) begin errs++; $display("FAIL b2b_errs got %0d want 0", err_seen); end
        vec++; if (a0 !== 7'h00) begin errs++; $display("FAIL b2b_addr0 got %h want 00", a0); end
        vec++; if (d0 !== 8'h11) begin errs++; $display("FAIL b2b_data0 got %h want 11", d0); end
        vec++; if (a1 !== 7'h04) begin errs++; $display("FAIL b2b_addr1 got %h want 04", a1); end
        vec++; if (d1 !== 8'h22) begin errs++; $display("FAIL b2b_data1 got %h want 22", d1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_range();
        test_bad_len();
        test_reset_midframe();
        test_readback();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
